// File: rtl/uart_rx_param_if.sv
// CPU-side bundle of the UART receiver: serial line in, FIFO pop in, FIFO head and status out.
// Latency: pure wiring, none.
// Backpressure: rd_en pops only when RX_VALID; a full FIFO drops words and flags RX_OVERRUN.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 UART_RX;
  logic                 rd_en;
  logic [DATA_BITS-1:0] RX_DATA;
  logic                 RX_PERR;
  logic                 RX_FERR;
  logic                 RX_VALID;
  logic                 RX_FULL;
  logic                 RX_OVERRUN;
  logic                 RX_BUSY;

  // Receiver side: consumes the line and pop, produces head word and status.
  modport master (
    input  UART_RX, rd_en,
    output RX_DATA, RX_PERR, RX_FERR, RX_VALID, RX_FULL, RX_OVERRUN, RX_BUSY
  );

  // CPU side: drives the line and pop, observes head word and status.
  modport slave (
    output UART_RX, rd_en,
    input  RX_DATA, RX_PERR, RX_FERR, RX_VALID, RX_FULL, RX_OVERRUN, RX_BUSY
  );
endinterface

// File: rtl/uart_rx_param.sv
// 16x-oversampling UART receiver: majority-vote sampling, parity/framing flags, show-ahead FIFO.
// Latency: RX_VALID rises 11+16*(data+parity+stop bits) clocks after the first low line sample.
// Backpressure: none on the line; a push into a full FIFO (without a pop) drops it and sets RX_OVERRUN.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             Clk_16_9600,
  input  logic             reset,
  uart_rx_param_if.master  bus
);
  localparam int FW = DATA_BITS + 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic          ODD_C   = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d, rxs_dly_q, rxs_dly_d;
  logic [1:0]           hist_q, hist_d;
  logic [3:0]           tick_q, tick_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovr_q, ovr_d;
  logic [FW-1:0]        fifo_mem [FIFO_DEPTH];

  logic                 rxs, vote, vote_edge, wrap, ferr_n, push;
  logic [FW-1:0]        push_word, head;
  logic                 pop, full, wr_ok, drop;

  // Receiver: synchroniser, bit sampling and frame state machine next-state logic.
  always_comb begin
    rxs        = sync2_q;
    sync1_d    = bus.UART_RX;
    sync2_d    = sync1_q;
    rxs_dly_d  = sync2_q;
    hist_d     = {hist_q[0], rxs};
    // Three consecutive samples around mid-bit; decision taken on the edge into tick 9.
    vote       = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);
    vote_edge  = (tick_q == 4'd8);
    wrap       = (tick_q == 4'd15);
    ferr_n     = ferr_q | ~vote;
    push_word  = {ferr_n, perr_q, data_q};
    push       = 1'b0;
    state_d    = state_q;
    tick_d     = tick_q + 4'd1;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    case (state_q)
      S_IDLE: begin
        tick_d = 4'd0;
        // Falling edge only: a line stuck low after a break cannot retrigger.
        if (rxs_dly_q && !rxs) begin
          state_d    = S_START;
          bit_cnt_d  = 4'd0;
          stop_cnt_d = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      S_START: begin
        if (vote_edge && vote) begin
          state_d = S_IDLE;
          tick_d  = 4'd0;
        end else if (wrap) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (vote_edge) begin
          data_d    = {vote, data_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (wrap && bit_cnt_q == 4'(DATA_BITS))
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (vote_edge)
          perr_d = (((^data_q) ^ vote) != ODD_C);
        if (wrap)
          state_d = S_STOP;
      end
      S_STOP: begin
        if (vote_edge) begin
          ferr_d = ferr_n;
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            // Leave early so a start edge in the tail of the stop bit is caught.
            push    = 1'b1;
            state_d = S_IDLE;
            tick_d  = 4'd0;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = 4'd0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // FIFO bookkeeping: pointers, occupancy and sticky overrun.
  always_comb begin
    pop      = bus.rd_en && (cnt_q != '0);
    full     = (cnt_q == DEPTH_C);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    wr_ok    = push && (!full || pop);
    drop     = push && full && !pop;
    wr_ptr_d = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({wr_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    ovr_d = drop ? 1'b1 : (pop ? 1'b0 : ovr_q);
  end

  // State register; reset aborts any frame and empties the FIFO.
  always_ff @(posedge Clk_16_9600 or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxs_dly_q  <= 1'b1;
      hist_q     <= 2'b11;
      tick_q     <= 4'd0;
      bit_cnt_q  <= 4'd0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rxs_dly_q  <= rxs_dly_d;
      hist_q     <= hist_d;
      tick_q     <= tick_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovr_q      <= ovr_d;
    end
  end

  // FIFO storage; contents need no reset since the head is masked while empty.
  always_ff @(posedge Clk_16_9600) begin
    if (wr_ok)
      fifo_mem[wr_ptr_q] <= push_word;
  end

  assign head           = fifo_mem[rd_ptr_q];
  assign bus.RX_VALID   = (cnt_q != '0);
  assign bus.RX_FULL    = full;
  assign bus.RX_OVERRUN = ovr_q;
  assign bus.RX_BUSY    = busy_q;
  assign bus.RX_DATA    = bus.RX_VALID ? head[DATA_BITS-1:0] : '0;
  assign bus.RX_PERR    = bus.RX_VALID & head[DATA_BITS];
  assign bus.RX_FERR    = bus.RX_VALID & head[DATA_BITS+1];
endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int   v0_rise = 0, b0_rise = 0, b0_fall = 0, v1_rise = 0, b1_fall = 0;
  logic v0_prev = 1'b0, b0_prev = 1'b0, v1_prev = 1'b0, b1_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(8)) if1 ();

  uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .Clk_16_9600(clk), .reset(reset), .bus(if0)
  );
  uart_rx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .Clk_16_9600(clk), .reset(reset), .bus(if1)
  );

  // Edge-index recorder for RX_VALID / RX_BUSY transitions, sampled 1ns after each edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (if0.RX_VALID && !v0_prev) v0_rise = cyc;
    if (if0.RX_BUSY && !b0_prev)  b0_rise = cyc;
    if (!if0.RX_BUSY && b0_prev)  b0_fall = cyc;
    if (if1.RX_VALID && !v1_prev) v1_rise = cyc;
    if (!if1.RX_BUSY && b1_prev)  b1_fall = cyc;
    v0_prev = if0.RX_VALID;
    b0_prev = if0.RX_BUSY;
    v1_prev = if1.RX_VALID;
    b1_prev = if1.RX_BUSY;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d, input logic stopb);
    return {6'b0, stopb, d, 1'b0};
  endfunction

  function automatic logic [15:0] f8p2(input logic [7:0] d, input logic par);
    return {4'b0, 2'b11, par, d, 1'b0};
  endfunction

  // Serial frame, LSB first, bit_ns per bit; c0 is the first edge that samples the start bit.
  task automatic send_bits(input int sel, input logic [15:0] bits, input int n,
                           input int bit_ns, output int c0);
    @(negedge clk);
    c0 = cyc + 1;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) if0.UART_RX = bits[i];
      else          if1.UART_RX = bits[i];
      #(bit_ns);
    end
    if (sel == 0) if0.UART_RX = 1'b1;
    else          if1.UART_RX = 1'b1;
  endtask

  task automatic pop(input int sel);
    @(negedge clk);
    if (sel == 0) if0.rd_en = 1'b1;
    else          if1.rd_en = 1'b1;
    @(negedge clk);
    if0.rd_en = 1'b0;
    if1.rd_en = 1'b0;
  endtask

  initial begin
    int c0;
    int ca;
    reset       = 1'b0;
    if0.UART_RX = 1'b1;
    if0.rd_en   = 1'b0;
    if1.UART_RX = 1'b1;
    if1.rd_en   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_data",  32'(if0.RX_DATA), 32'h0);
    chk("rst_valid", 32'(if0.RX_VALID), 32'h0);
    chk("rst_full",  32'(if0.RX_FULL), 32'h0);
    chk("rst_ovr",   32'(if0.RX_OVERRUN), 32'h0);
    chk("rst_busy",  32'(if0.RX_BUSY), 32'h0);
    chk("rst_perr",  32'(if0.RX_PERR), 32'h0);
    chk("rst_ferr",  32'(if0.RX_FERR), 32'h0);
    chk("rst_valid1", 32'(if1.RX_VALID), 32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 0xA5 at exact baud
    send_bits(0, f8n1(8'hA5, 1'b1), 10, 160, c0);
    repeat (4) @(negedge clk);
    chk("a5_busy_rise",  32'(b0_rise - c0), 32'd2);
    chk("a5_valid_rise", 32'(v0_rise - c0), 32'd155);
    chk("a5_busy_fall",  32'(b0_fall - c0), 32'd155);
    chk("a5_data", 32'(if0.RX_DATA), 32'hA5);
    chk("a5_perr", 32'(if0.RX_PERR), 32'h0);
    chk("a5_ferr", 32'(if0.RX_FERR), 32'h0);
    pop(0);
    chk("a5_pop_valid", 32'(if0.RX_VALID), 32'h0);
    chk("a5_pop_data",  32'(if0.RX_DATA), 32'h0);

    // 4-clock low glitch: false start
    @(negedge clk);
    if0.UART_RX = 1'b0;
    c0 = cyc + 1;
    repeat (4) @(negedge clk);
    if0.UART_RX = 1'b1;
    repeat (30) @(negedge clk);
    chk("gl_busy_rise", 32'(b0_rise - c0), 32'd2);
    chk("gl_busy_fall", 32'(b0_fall - c0), 32'd11);
    chk("gl_valid", 32'(if0.RX_VALID), 32'h0);

    // Even parity, two stops: 0x3C with wrong then right parity bit (second at +3% slow baud)
    send_bits(1, f8p2(8'h3C, 1'b1), 12, 160, c0);
    repeat (4) @(negedge clk);
    chk("par_valid_rise", 32'(v1_rise - c0), 32'd187);
    chk("par_busy_fall",  32'(b1_fall - c0), 32'd187);
    chk("par_bad_data", 32'(if1.RX_DATA), 32'h3C);
    chk("par_bad_perr", 32'(if1.RX_PERR), 32'h1);
    chk("par_bad_ferr", 32'(if1.RX_FERR), 32'h0);
    pop(1);
    send_bits(1, f8p2(8'h3C, 1'b0), 12, 165, c0);
    repeat (4) @(negedge clk);
    chk("par_ok_data", 32'(if1.RX_DATA), 32'h3C);
    chk("par_ok_perr", 32'(if1.RX_PERR), 32'h0);
    pop(1);
    chk("par_empty", 32'(if1.RX_VALID), 32'h0);

    // Framing error then good word (+3% slow baud)
    send_bits(0, f8n1(8'h55, 1'b0), 10, 160, c0);
    repeat (20) @(negedge clk);
    send_bits(0, f8n1(8'h81, 1'b1), 10, 165, c0);
    repeat (4) @(negedge clk);
    chk("fe1_data", 32'(if0.RX_DATA), 32'h55);
    chk("fe1_ferr", 32'(if0.RX_FERR), 32'h1);
    chk("fe1_perr", 32'(if0.RX_PERR), 32'h0);
    pop(0);
    chk("fe2_data", 32'(if0.RX_DATA), 32'h81);
    chk("fe2_ferr", 32'(if0.RX_FERR), 32'h0);
    pop(0);
    chk("fe_empty", 32'(if0.RX_VALID), 32'h0);

    // FIFO fill and overrun; word 3 at -3% fast baud
    for (int i = 1; i <= 5; i++) begin
      send_bits(0, f8n1(8'(i), 1'b1), 10, (i == 3) ? 155 : 160, c0);
      repeat (2) @(negedge clk);
      if (i == 4) begin
        chk("ff_full4", 32'(if0.RX_FULL), 32'h1);
        chk("ff_ovr4",  32'(if0.RX_OVERRUN), 32'h0);
      end
    end
    chk("ff_ovr5",  32'(if0.RX_OVERRUN), 32'h1);
    chk("ff_full5", 32'(if0.RX_FULL), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ff_pop%0d_data", i), 32'(if0.RX_DATA), 32'(i));
      pop(0);
      if (i == 1) begin
        chk("ff_ovr_clr", 32'(if0.RX_OVERRUN), 32'h0);
        chk("ff_full_clr", 32'(if0.RX_FULL), 32'h0);
      end
    end
    chk("ff_empty", 32'(if0.RX_VALID), 32'h0);

    // Reset at bit 4 of a frame while a word sits in the FIFO
    send_bits(0, f8n1(8'h11, 1'b1), 10, 160, c0);
    repeat (2) @(negedge clk);
    chk("ab_pre_valid", 32'(if0.RX_VALID), 32'h1);
    fork
      send_bits(0, f8n1(8'hF8, 1'b1), 10, 160, ca);
      begin
        repeat (72) @(negedge clk);
        chk("ab_busy_before", 32'(if0.RX_BUSY), 32'h1);
        reset = 1'b0;
        #1;
        chk("ab_rst_data",  32'(if0.RX_DATA), 32'h0);
        chk("ab_rst_valid", 32'(if0.RX_VALID), 32'h0);
        chk("ab_rst_full",  32'(if0.RX_FULL), 32'h0);
        chk("ab_rst_ovr",   32'(if0.RX_OVERRUN), 32'h0);
        chk("ab_rst_busy",  32'(if0.RX_BUSY), 32'h0);
        chk("ab_rst_perr",  32'(if0.RX_PERR), 32'h0);
        chk("ab_rst_ferr",  32'(if0.RX_FERR), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    chk("ab_post_valid", 32'(if0.RX_VALID), 32'h0);
    chk("ab_post_busy",  32'(if0.RX_BUSY), 32'h0);
    send_bits(0, f8n1(8'h9F, 1'b1), 10, 160, c0);
    repeat (4) @(negedge clk);
    chk("ab_9f_data", 32'(if0.RX_DATA), 32'h9F);
    chk("ab_9f_ferr", 32'(if0.RX_FERR), 32'h0);
    pop(0);
    chk("ab_9f_only", 32'(if0.RX_VALID), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
